serial_adder: RTL and testbench

Multi-cycle, parametrised binary adder that adds two WIDTH-bit operands plus carry-in by processing SLICE bits per clock through a ripple chain of full-adder cells, carrying between slices in a register. It generalises the single-bit combinational full adder into a sequential datapath unit with valid/ready handshakes on input and output. It sits between an operand source (register file or bench driver) and a result consumer, trading latency for area at large WIDTH.

---
 rtl/serial_adder_pkg.sv | 24 ++
 rtl/adder_slice.sv | 32 +++
 rtl/serial_adder.sv | 133 +++++++++++++
 tb/tb_serial_adder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the serial adder.
// Optional feature macro: SERIAL_ADDER_OVF_EN (signed overflow output).
package serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Number of slice cycles needed for one add.
    function automatic int unsigned calc_n(input int unsigned width, input int unsigned slice);
        return width / slice;
    endfunction

    // Slice counter width; never narrower than one bit so N == 1 still has a counter.
    function automatic int unsigned calc_cnt_w(input int unsigned width,
                                               input int unsigned slice);
        int unsigned n;
        n = width / slice;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple-carry chain of full-adder cells.
// Optional feature macro: SERIAL_ADDER_OVF_EN (exposes carry into the MSB cell).
module adder_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             c
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             c_msb_in
`endif
);

    logic [SLICE:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign s[i]           = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign c = w_carry[SLICE];

`ifdef SERIAL_ADDER_OVF_EN
    assign c_msb_in = w_carry[SLICE-1];
`endif

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: adds SLICE bits per clock with the carry held in a register,
// valid/ready handshakes on both sides.
// Optional feature macro: SERIAL_ADDER_OVF_EN (adds the ovf signed-overflow port).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N    = calc_n(WIDTH, SLICE);
    localparam int unsigned CntW = calc_cnt_w(WIDTH, SLICE);

    state_e            r_state;
    state_e            w_state_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_s;
    logic [WIDTH-1:0]  w_s_next;
    logic              r_carry;
    logic              r_cout;
    logic [CntW-1:0]   r_cnt;
    logic              w_accept;
    logic              w_last;
    logic [SLICE-1:0]  w_sum;
    logic              w_slice_c;
`ifdef SERIAL_ADDER_OVF_EN
    logic              r_ovf;
    logic              w_msb_c;
`endif

    assign w_accept = in_valid && (r_state == StIdle);
    assign w_last   = (r_state == StRun) && (r_cnt == CntW'(N - 1));

    adder_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a        (r_a[SLICE-1:0]),
        .b        (r_b[SLICE-1:0]),
        .cin      (r_carry),
        .s        (w_sum),
        .c        (w_slice_c)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .c_msb_in (w_msb_c)
`endif
    );

    // New sum slice enters at the MSB end; after N shifts r_s holds the full sum.
    if (N == 1) begin : g_s_single
        assign w_s_next = w_sum;
    end else begin : g_s_shift
        assign w_s_next = {w_sum, r_s[WIDTH-1:SLICE]};
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (in_valid)  w_state_next = StRun;
            StRun:   if (w_last)    w_state_next = StDone;
            StDone:  if (out_ready) w_state_next = StIdle;
            default:                w_state_next = StIdle;
        endcase
    end

    // Operand shift registers, carry, counter and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == StRun) begin
            r_a     <= r_a >> SLICE;
            r_b     <= r_b >> SLICE;
            r_s     <= w_s_next;
            r_carry <= w_slice_c;
            r_cnt   <= r_cnt + CntW'(1);
            if (w_last) begin
                r_cout <= w_slice_c;
`ifdef SERIAL_ADDER_OVF_EN
                // Signed overflow: carry into MSB differs from carry out of MSB.
                r_ovf  <= w_msb_c ^ w_slice_c;
`endif
            end
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign s         = r_s;
    assign cout      = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: 32/4 instance with directed, backpressure,
// reset and random traffic; an 8/8 instance covers the single-slice case.
// Optional feature macro: SERIAL_ADDER_OVF_EN (ovf is checked when defined).
module tb_serial_adder;

    localparam int unsigned W  = 32;
    localparam int unsigned SL = 4;
    localparam int unsigned NC = W / SL;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s_o;
    logic         cout_o;
    logic         ovf_o;

    logic         d2_in_valid;
    logic         d2_in_ready;
    logic [7:0]   d2_a;
    logic [7:0]   d2_b;
    logic         d2_cin;
    logic         d2_out_valid;
    logic         d2_out_ready;
    logic [7:0]   d2_s;
    logic         d2_cout;
    logic         d2_ovf;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   mode    = 0;   // 0: always ready, 1: random ready, 2: hold ready low
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(
        .WIDTH (W),
        .SLICE (SL)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .cin       (cin_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s_o),
        .cout      (cout_o)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf_o)
`endif
    );

    serial_adder #(
        .WIDTH (8),
        .SLICE (8)
    ) dut2 (
        .clk       (clk),
        .reset     (rst),
        .in_valid  (d2_in_valid),
        .in_ready  (d2_in_ready),
        .a         (d2_a),
        .b         (d2_b),
        .cin       (d2_cin),
        .out_valid (d2_out_valid),
        .out_ready (d2_out_ready),
        .s         (d2_s),
        .cout      (d2_cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (d2_ovf)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf_o  = 1'b0;
    assign d2_ovf = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain wide addition; overflow from operand/result sign rule.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input int acc);
        exp_t        m;
        logic [W:0]  full;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        m.s    = full[W-1:0];
        m.cout = full[W];
        m.ovf  = (a[W-1] == b[W-1]) && (m.s[W-1] != a[W-1]);
        m.acc  = acc;
        return m;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        a_i      = a;
        b_i      = b;
        cin_i    = cin;
        while (!in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(model(a, b, cin, cyc + 1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compare each result on first sight, then check it stays stable until taken.
    initial begin
        exp_t         e;
        logic         seen = 1'b0;
        logic [W-1:0] hold_s = '0;
        logic         hold_c = 1'b0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
                continue;
            end
            if (out_valid) begin
                if (!seen) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out_valid", 64'(out_valid), 64'd0);
                    end else begin
                        e = sb[0];
                        check("latency", 64'(cyc - e.acc), 64'(NC));
                        check("sum", 64'(s_o), 64'(e.s));
                        check("cout", 64'(cout_o), 64'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
                        check("ovf", 64'(ovf_o), 64'(e.ovf));
`endif
                    end
                    hold_s = s_o;
                    hold_c = cout_o;
                    seen   = 1'b1;
                end else begin
                    check("hold_sum", 64'(s_o), 64'(hold_s));
                    check("hold_cout", 64'(cout_o), 64'(hold_c));
                    check("hold_in_ready", 64'(in_ready), 64'd0);
                end
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = 1'($urandom_range(0, 1));
                    default: out_ready = 1'b0;
                endcase
                if (out_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    seen = 1'b0;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        a_i          = '0;
        b_i          = '0;
        cin_i        = 1'b0;
        d2_in_valid  = 1'b0;
        d2_a         = '0;
        d2_b         = '0;
        d2_cin       = 1'b0;
        d2_out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(s_o), 64'd0);
        check("rst_cout", 64'(cout_o), 64'd0);
        check("rst_ovf", 64'(ovf_o), 64'd0);
        check("rst_d2_in_ready", 64'(d2_in_ready), 64'd1);
        rst = 1'b0;

        // Directed corner values.
        send(32'h1, 32'h0, 1'b0);
        send(32'h1, 32'h0, 1'b1);
        send(32'h1, 32'h1, 1'b1);
        send(32'hFFFF_FFFF, 32'h1, 1'b0);
        send(32'h7FFF_FFFF, 32'h1, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b1);
        drain();

        // Backpressure: garbage in_valid during RUN and DONE must not be accepted.
        mode = 2;
        send(32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("run_in_ready", 64'(in_ready), 64'd0);
            in_valid = 1'b1;
            a_i      = $urandom;
            b_i      = $urandom;
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
        begin
            int guard = 0;
            while (!out_valid && guard < 100) begin
                @(negedge clk);
                guard++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            in_valid = 1'b1;
            a_i      = $urandom;
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
        mode = 0;
        drain();

        // Asynchronous reset during the second RUN cycle aborts the add.
        @(negedge clk);
        check("pre_rst_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a_i      = 32'hFFFF_FFFF;
        b_i      = 32'h0;
        cin_i    = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_sum", 64'(s_o), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        send(32'h10, 32'h20, 1'b0);
        drain();

        // Randomised traffic with random consumer backpressure.
        mode = 1;
        for (int i = 0; i < 1000; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        drain();
        mode = 0;

        // Single-slice instance: one RUN cycle, result after one cycle.
        for (int i = 0; i < 4; i++) begin
            logic [8:0] full;
            logic [7:0] ea;
            logic [7:0] eb;
            logic       ec;
            ea = (i == 0) ? 8'hAA : 8'($urandom);
            eb = (i == 0) ? 8'h55 : 8'($urandom);
            ec = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            full = {1'b0, ea} + {1'b0, eb} + {8'd0, ec};
            @(negedge clk);
            check("d2_in_ready", 64'(d2_in_ready), 64'd1);
            d2_in_valid = 1'b1;
            d2_a        = ea;
            d2_b        = eb;
            d2_cin      = ec;
            @(posedge clk);
            #1 d2_in_valid = 1'b0;
            @(negedge clk);
            check("d2_run_out_valid", 64'(d2_out_valid), 64'd0);
            @(negedge clk);
            check("d2_out_valid", 64'(d2_out_valid), 64'd1);
            check("d2_sum", 64'(d2_s), 64'(full[7:0]));
            check("d2_cout", 64'(d2_cout), 64'(full[8]));
`ifdef SERIAL_ADDER_OVF_EN
            check("d2_ovf", 64'(d2_ovf), 64'((ea[7] == eb[7]) && (full[7] != ea[7])));
`endif
            @(negedge clk);
            check("d2_back_idle", 64'(d2_in_ready), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
